// File: rtl/div_seq_pkg.sv
// Shared CPU definitions for the sequential divider: div_op bit positions
// (also decoded by the ID stage) and the divider FSM state encodings.
package div_seq_pkg;

  localparam int DIV_SIGNED = 0;
  localparam int DIV_MOD    = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_seq.sv
// Sequential 32-cycle restoring divider for DIV.W / MOD.W / DIV.WU / MOD.WU,
// with valid/ready handshakes on both sides and a flush abort.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_if(input logic [WIDTH-1:0] v,
                                              input logic             en);
    return (en && v[WIDTH-1]) ? twos_neg(v) : v;
  endfunction

  div_state_e         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] rq_q, rq_d;     // {remainder, quotient/dividend}
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [1:0]         op_q, op_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;

  logic               accept;
  logic               signed_op;
  logic               dvs_zero;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               borrow;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;

  assign in_ready  = (state_q == S_IDLE) & ~flush;
  assign accept    = in_valid & in_ready;
  assign signed_op = div_op[DIV_SIGNED];
  assign dvs_zero  = (src2 == '0);

  // One restoring step: shift next dividend bit into the remainder, trial-subtract.
  assign trial            = {rq_q[2*WIDTH-1:WIDTH], rq_q[WIDTH-1]};
  assign {borrow, diff}   = {1'b0, trial} - {2'b00, dvs_q};
  assign rem_nx           = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nx           = {rq_q[WIDTH-2:0], ~borrow};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rq_d    = rq_q;
    dvs_d   = dvs_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_CALC;
          cnt_d   = '0;
          op_d    = div_op;
          // A zero divisor keeps the raw dividend so the remainder equals src1.
          rq_d    = {{WIDTH{1'b0}}, dvs_zero ? src1 : abs_if(src1, signed_op)};
          dvs_d   = abs_if(src2, signed_op);
          negq_d  = signed_op & (src1[WIDTH-1] ^ src2[WIDTH-1]) & ~dvs_zero;
          negr_d  = signed_op & src1[WIDTH-1] & ~dvs_zero;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH - 1)) begin
          state_d = S_DONE;
          rq_d    = {negr_q ? twos_neg(rem_nx) : rem_nx,
                     negq_q ? twos_neg(quo_nx) : quo_nx};
        end else begin
          rq_d = {rem_nx, quo_nx};
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      rq_q   <= '0;
      dvs_q  <= '0;
      op_q   <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rq_q   <= rq_d;
      dvs_q  <= dvs_d;
      op_q   <= op_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = !out_valid     ? '0 :
                     op_q[DIV_MOD]  ? rq_q[2*WIDTH-1:WIDTH] : rq_q[WIDTH-1:0];

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, signed/unsigned results,
// divide-by-zero, overflow, backpressure, flush and asynchronous reset.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  div_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .div_op    (div_op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request at the negedge, accept on the next posedge, then scramble inputs.
  task automatic start(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    div_op   = op;
    src1     = a;
    src2     = b;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src1     = ~a;
    src2     = 32'h3;
    div_op   = ~op;
  endtask

  // Check latency to the result, the result value, and the single-cycle drain.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    start(tag, op, a, b);
    step(31);
    chk({tag, ".early_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".busy_calc"}, {31'd0, busy}, 32'd1);
    step(1);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".result"}, result, exp);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk({tag, ".drained"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".idle_result"}, result, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    div_op    = 2'b00;
    src1      = '0;
    src2      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    step(2);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b1;
    #1;
    chk("rst.in_ready_flush", {31'd0, in_ready}, 32'd0);
    flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    run_op("udiv", 2'b00, 32'd100, 32'd7, 32'd14);
    run_op("umod", 2'b10, 32'd100, 32'd7, 32'd2);
    run_op("sdiv", 2'b01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_op("smod", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_op("udiv_big", 2'b00, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF);
    run_op("umod_big", 2'b10, 32'hFFFFFFFF, 32'h10, 32'h0000000F);
    run_op("dz_udiv", 2'b00, 32'h12345678, 32'd0, 32'hFFFFFFFF);
    run_op("dz_umod", 2'b10, 32'h12345678, 32'd0, 32'h12345678);
    run_op("dz_sdiv", 2'b01, 32'h12345678, 32'd0, 32'hFFFFFFFF);
    run_op("dz_smod", 2'b11, 32'h12345678, 32'd0, 32'h12345678);
    run_op("ovf_div", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op("ovf_mod", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);

    // Backpressure in DONE
    start("bp", 2'b00, 32'd100, 32'd7);
    step(32);
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", {31'd0, out_valid}, 32'd1);
      chk("bp.result", result, 32'd14);
      chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
      step(1);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("bp.transfer", {31'd0, out_valid}, 32'd0);
    step(1);
    chk("bp.single", {31'd0, out_valid}, 32'd0);
    chk("bp.idle_busy", {31'd0, busy}, 32'd0);

    // Flush at iteration 10 with a competing request
    start("fl_calc", 2'b00, 32'd100, 32'd7);
    step(10);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    src1     = 32'd50;
    src2     = 32'd5;
    div_op   = 2'b00;
    chk("fl_calc.in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_calc.busy", {31'd0, busy}, 32'd0);
    chk("fl_calc.valid", {31'd0, out_valid}, 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        step(1);
        if (out_valid || busy) seen++;
      end
      chk("fl_calc.no_result", seen, 32'd0);
    end

    // Flush in DONE
    start("fl_done", 2'b10, 32'd100, 32'd7);
    step(32);
    chk("fl_done.valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl_done.dropped", {31'd0, out_valid}, 32'd0);
    chk("fl_done.busy", {31'd0, busy}, 32'd0);
    run_op("after_flush", 2'b00, 32'd100, 32'd7, 32'd14);

    // Asynchronous reset mid-CALC, between edges
    start("arst", 2'b00, 32'd100, 32'd7);
    step(5);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.busy", {31'd0, busy}, 32'd0);
    chk("arst.valid", {31'd0, out_valid}, 32'd0);
    chk("arst.result", result, 32'd0);
    chk("arst.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    run_op("after_rst", 2'b00, 32'd100, 32'd7, 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
